i8bit_div: RTL and testbench

- Sequential restoring divider. The inverse companion to the combinational 8-bit Vedic multiplier.
- Accepts an unsigned dividend/divisor pair over a valid/ready handshake and produces one quotient bit per clock.
- Presents quotient and remainder on a held output handshake.
- Sits beside `i8bit_mul` in the arithmetic datapath. Benches use the pair for the round-trip check a = q*b + r.

---
 rtl/i8bit_div_pkg.sv | 15 +
 rtl/i8bit_div_step.sv | 22 ++
 rtl/i8bit_div.sv | 102 ++++++++++
 tb/tb_i8bit_div.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/i8bit_div_pkg.sv
// rtl/i8bit_div_pkg.sv - shared state encoding and constants for the restoring divider
package i8bit_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W = 8;

    // Every bit of the divide-by-zero quotient; replicated to the operand width.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/i8bit_div_step.sv
// rtl/i8bit_div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Keep the carry-out bit of the shift: with divisor > 2^(WIDTH-1) the
    // trial value can exceed WIDTH bits before subtraction.
    assign trial    = {rem, dividend_bit};
    assign diff     = trial - {1'b0, divisor};
    assign q_bit    = (trial >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/i8bit_div.sv
// rtl/i8bit_div.sv - sequential restoring divider with valid/ready operand and result handshakes
module i8bit_div
    import i8bit_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    div_state_t       state_next;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [CW-1:0]    count;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem),
        .dividend_bit (dividend[WIDTH-1]),
        .divisor      (divisor),
        .rem_next     (step_rem),
        .q_bit        (step_bit)
    );

    assign last_step = (count == CW'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (b == '0) ? DONE : BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend    <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dividend <= a;
                        divisor  <= b;
                        rem      <= '0;
                        quo      <= '0;
                        count    <= '0;
                        if (b == '0) begin
                            q           <= {WIDTH{DIV_ZERO_Q_BIT}};
                            r           <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    rem      <= step_rem;
                    quo      <= {quo[WIDTH-2:0], step_bit};
                    dividend <= dividend << 1;
                    count    <= count + 1'b1;
                    if (last_step) begin
                        q           <= {quo[WIDTH-2:0], step_bit};
                        r           <= step_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i8bit_div.sv
// tb/tb_i8bit_div.sv - directed and throttled-random scoreboard bench for i8bit_div
module tb_i8bit_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q;
    logic [7:0] r;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];

    i8bit_div #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference values from plain integer arithmetic, independent of the shift/subtract datapath.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e.a = x;
        e.b = y;
        if (y == 0) begin
            e.q = 8'd255; e.r = x; e.dbz = 1'b1;
        end else begin
            e.q = x / y; e.r = x % y; e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int hold, input bit detail);
        exp_t e;
        int   lat;
        int   w;
        logic [7:0] q0, r0;
        w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(x, y));
        step();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            if (detail) chk("in_ready_busy", in_ready, 0);
            step();
            lat++;
        end
        chk("latency", lat, (y == 0) ? 1 : 9);
        if (detail) chk("in_ready_done", in_ready, 0);
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        if (!e.dbz) begin
            chk("roundtrip", 32'(q) * 32'(e.b) + 32'(r), 32'(e.a));
            chk("r_lt_b", (r < e.b), 1);
        end
        q0 = q; r0 = r;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (detail) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_q", q, q0);
                chk("hold_r", r, r0);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("back_idle", in_ready, 1);
        chk("valid_drop", out_valid, 0);
        if (detail) begin
            chk("idle_q", q, q0);
            chk("idle_r", r, r0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        do_op(8'd60, 8'd5, 0, 1'b1);
        do_op(8'd255, 8'd16, 0, 1'b1);
        do_op(8'd171, 8'd205, 0, 1'b1);
        do_op(8'd255, 8'd1, 0, 1'b1);
        do_op(8'd200, 8'd0, 0, 1'b1);
        do_op(8'd10, 8'd3, 0, 1'b1);
        do_op(8'd238, 8'd15, 20, 1'b1);
        do_op(8'd0, 8'd7, 0, 1'b1);
        do_op(8'd99, 8'd99, 0, 1'b1);
        do_op(8'd200, 8'd129, 0, 1'b1);

        // Mid-operation reset discards the in-flight result.
        a = 8'd240; b = 8'd15; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_q", q, 0);
        chk("mid_rst_r", r, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        do_op(8'd240, 8'd15, 0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            do_op(x, y, $urandom_range(0, 3), (i < 20));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
